// File: rtl/flex_down_counter.sv
// flex_down_counter: loadable, prescaled down-counter with busy status and a
// single-cycle terminal pulse (zero_flag). States IDLE -> RUN -> DONE -> IDLE.
// Optional auto-reload (periodic tick mode) is compiled in when the macro
// FLEX_DOWN_AUTO_RELOAD_EN is defined; otherwise reload_en is ignored.
module flex_down_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_PRE_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    reload_en,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_PRE_BITS-1:0] prescale_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    zero_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_PRE_BITS-1:0] pre_cnt_q, pre_cnt_d;
    logic [NUM_PRE_BITS-1:0] pre_val_q, pre_val_d;
    logic                    zero_q, zero_d;
    logic                    busy_q, busy_d;
    logic                    reload_act;
    logic                    tick;

`ifdef FLEX_DOWN_AUTO_RELOAD_EN
    assign reload_act = reload_en;
`else
    logic unused_reload_en;
    assign unused_reload_en = reload_en;
    assign reload_act       = 1'b0;
`endif

    // Prescaler terminal: one count step every pre_val_q+1 unpaused RUN cycles
    always_comb begin
        tick = (state_q == RUN) && !pause && (pre_cnt_q == pre_val_q);
    end

    // Next-state logic: clear > start > pause > normal count
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        pre_val_d = pre_val_q;
        zero_d    = 1'b0;

        if (clear) begin
            state_d   = IDLE;
            count_d   = '0;
            pre_cnt_d = '0;
        end else if (start) begin
            pre_val_d = prescale_val;
            pre_cnt_d = '0;
            if (load_val != '0) begin
                count_d = load_val;
                state_d = RUN;
            end else begin
                count_d = '0;
                zero_d  = 1'b1;
                state_d = DONE;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!pause) begin
                        if (tick) begin
                            pre_cnt_d = '0;
                            if (count_q > NUM_CNT_BITS'(1)) begin
                                count_d = count_q - NUM_CNT_BITS'(1);
                            end else if (reload_act && (load_val != '0)) begin
                                // Terminal tick with reload: pulse and keep running
                                count_d = load_val;
                                zero_d  = 1'b1;
                            end else begin
                                count_d = '0;
                                zero_d  = 1'b1;
                                state_d = DONE;
                            end
                        end else begin
                            pre_cnt_d = pre_cnt_q + NUM_PRE_BITS'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // busy is registered alongside the state so it changes on the same edge
    always_comb begin
        busy_d = (state_d == RUN);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pre_cnt_q <= '0;
            pre_val_q <= '0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            pre_val_q <= pre_val_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
        end
    end

    assign count_out = count_q;
    assign busy      = busy_q;
    assign zero_flag = zero_q;

endmodule

// File: tb/tb_flex_down_counter.sv
// Scoreboard bench for flex_down_counter: the driver applies stimulus, steps a
// cycle-level reference model and queues the expected outputs; the monitor
// samples the DUT after each clock edge (or reset assertion) and compares.
module tb_flex_down_counter;

    localparam int CW = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          reload_en = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic [PW-1:0] prescale_val = '0;
    logic [CW-1:0] count_out;
    logic          busy;
    logic          zero_flag;

    flex_down_counter #(
        .NUM_CNT_BITS(CW),
        .NUM_PRE_BITS(PW)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .start       (start),
        .pause       (pause),
        .reload_en   (reload_en),
        .load_val    (load_val),
        .prescale_val(prescale_val),
        .count_out   (count_out),
        .busy        (busy),
        .zero_flag   (zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cnt;
        bit    busy;
        bit    zero;
        string tag;
    } exp_t;

    exp_t  sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    done = 1'b0;
    string cur_tag = "reset";
    int    last_lv = 0;
    int    last_pv = 0;

`ifdef FLEX_DOWN_AUTO_RELOAD_EN
    localparam bit RELOAD_ON = 1'b1;
`else
    localparam bit RELOAD_ON = 1'b0;
`endif

    // Reference model: remaining count plus cycles left until the next step
    int m_cnt = 0;
    int m_period = 1;
    int m_wait = 0;
    bit m_run = 1'b0;
    bit m_zero = 1'b0;

    task automatic model_reset();
        m_cnt  = 0;
        m_wait = 0;
        m_run  = 1'b0;
        m_zero = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit s, input bit p, input bit r,
                              input int lv, input int pv);
        m_zero = 1'b0;
        if (c) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (s) begin
            m_period = pv + 1;
            m_wait   = m_period;
            if (lv != 0) begin
                m_cnt = lv;
                m_run = 1'b1;
            end else begin
                m_cnt  = 0;
                m_zero = 1'b1;
                m_run  = 1'b0;
            end
        end else if (m_run && !p) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_wait = m_period;
                if (m_cnt > 1) begin
                    m_cnt = m_cnt - 1;
                end else begin
                    m_zero = 1'b1;
                    if (RELOAD_ON && r && lv != 0) begin
                        m_cnt = lv;
                    end else begin
                        m_cnt = 0;
                        m_run = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.cnt  = m_cnt;
        e.busy = m_run;
        e.zero = m_zero;
        e.tag  = cur_tag;
        sb.push_back(e);
    endtask

    // Apply one cycle of inputs, predict the outputs after the next edge
    task automatic cycle(input bit c, input bit s, input bit p, input bit r,
                         input int lv, input int pv);
        clear        = c;
        start        = s;
        pause        = p;
        reload_en    = r;
        load_val     = CW'(lv);
        prescale_val = PW'(pv);
        last_lv      = lv;
        last_pv      = pv;
        if (n_rst) model_step(c, s, p, r, lv, pv);
        else model_reset();
        push_exp();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input int n, input bit p, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, p, r, last_lv, last_pv);
    endtask

    task automatic async_reset(input int held_cycles);
        model_reset();
        push_exp();
        n_rst = 1'b0;
        hold(held_cycles, 1'b0, 1'b0);
        n_rst = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation
    initial begin
        forever begin
            @(posedge clk or negedge n_rst);
            #1;
            if (done) break;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_empty: DUT output count_out=%0d with no expectation queued", count_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (count_out !== CW'(e.cnt) || busy !== e.busy || zero_flag !== e.zero) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got count_out=%0d busy=%0b zero_flag=%0b, want count_out=%0d busy=%0b zero_flag=%0b",
                             e.tag, $time, count_out, busy, zero_flag, e.cnt, e.busy, e.zero);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        cur_tag = "reset";
        async_reset(2);
        hold(2, 1'b0, 1'b0);

        cur_tag = "basic_l5_p0";
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 5, 0);
        hold(7, 1'b0, 1'b0);

        cur_tag = "prescale_l3_p2";
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3, 2);
        hold(11, 1'b0, 1'b0);

        cur_tag = "pause_l4";
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4, 0);
        hold(1, 1'b0, 1'b0);
        hold(2, 1'b1, 1'b0);
        hold(6, 1'b0, 1'b0);

        cur_tag = "clear_mid_run";
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 6, 1);
        hold(3, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 6, 1);
        hold(3, 1'b0, 1'b0);

        cur_tag = "zero_load";
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        hold(3, 1'b0, 1'b0);

        cur_tag = "restart";
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 5, 0);
        hold(3, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 7, 0);
        hold(9, 1'b0, 1'b0);

        cur_tag = "start_on_tick";
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
        hold(1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
        hold(4, 1'b0, 1'b0);

        cur_tag = "auto_reload";
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 2, 1);
        hold(12, 1'b0, 1'b1);
        hold(8, 1'b0, 1'b0);

        cur_tag = "async_reset_mid";
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 6, 0);
        hold(3, 1'b0, 1'b0);
        async_reset(1);
        hold(2, 1'b0, 1'b0);

        cur_tag = "random";
        for (int i = 0; i < 3000; i++) begin
            bit c, s, p, r;
            int lv, pv;
            if ($urandom_range(0, 499) == 0) begin
                async_reset(1);
            end else begin
                c  = ($urandom_range(0, 39) == 0);
                s  = ($urandom_range(0, 11) == 0);
                p  = ($urandom_range(0, 4) == 0);
                r  = ($urandom_range(0, 3) != 0);
                lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
                pv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
                cycle(c, s, p, r, lv, pv);
            end
        end

        done = 1'b1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flex_down_counter.md
# flex_down_counter

Loadable, prescaled down-counter that complements the flex up-counter in the miner datapath. Control logic (nonce sweep limits, hash-round budgets, watchdog timeouts) loads a count and start value; the block counts down to zero at a programmable tick rate. It reports progress, busy status and a single-cycle terminal pulse. An optional auto-reload mode turns it into a periodic tick generator.

## Interface
- NUM_CNT_BITS, 4, width of count and load value
- NUM_PRE_BITS, 4, width of prescaler compare value
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- clear  input  1  synchronous clear, highest priority after reset
- start  input  1  capture load_val/prescale_val and begin counting
- pause  input  1  freeze prescaler and count while high (RUN only)
- reload_en  input  1  auto-reload request (honoured only with FLEX_DOWN_AUTO_RELOAD_EN)
- load_val  input  NUM_CNT_BITS  starting count
- prescale_val  input  NUM_PRE_BITS  ticks every prescale_val+1 cycles
- count_out  output  NUM_CNT_BITS  current count (registered)
- busy  output  1  high in RUN
- zero_flag  output  1  one-cycle pulse on reaching terminal count (registered)

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE; reset values: count_out=0, busy=0, zero_flag=0, prescaler=0, latched prescale=0.
- Priority per edge: clear > start > pause > normal count.
- clear: state IDLE, count_out=0, prescaler=0, zero_flag=0, any state.
- start (any state, including RUN = restart): latch prescale_val, prescaler<=0.
  - load_val!=0: count_out<=load_val, state RUN.
  - load_val==0: count_out<=0, zero_flag<=1, state DONE (no RUN).
- RUN: tick when prescaler==latched prescale, prescaler<=0; else prescaler+1. pause holds prescaler and count_out; zero_flag stays 0.
- On tick with count_out>1: count_out-1.
- On tick with count_out==1 (terminal):
  - reload inactive: count_out<=0, zero_flag<=1, state DONE.
  - reload active: count_out<=load_val (live value; 0 treated as terminal -> DONE), zero_flag<=1, remain RUN.
- DONE: one cycle, busy=0, count_out holds 0, then IDLE. zero_flag is 1 only during the DONE cycle (or the cycle after a reload tick).
- IDLE: count_out holds, no prescaler activity.
- Arithmetic: unsigned, no wrap below 0; count_out never decrements from 0.

## Timing
- Start latency: start sampled at edge k -> count_out=load_val, busy=1 after edge k.
- Each decrement spaced exactly prescale_val+1 cycles; first decrement at edge k+prescale_val+1.
- count_out reaches 0 at edge k+load_val*(prescale_val+1) with no pause; each paused cycle adds one.
- zero_flag asserted same cycle count_out first shows 0 (or reloaded value); width exactly 1 cycle.
- busy deasserts on the same edge zero_flag asserts (non-reload).
- Asynchronous reset mid-RUN: all outputs to reset values immediately; no zero_flag.
- start and tick on the same edge: start wins, no zero_flag.

## Configuration
- FLEX_DOWN_AUTO_RELOAD_EN defined: reload_en is honoured; terminal tick with reload_en=1 reloads load_val and keeps RUN, producing a periodic zero_flag every load_val*(prescale_val+1) cycles.
- Not defined: reload_en is ignored (treated 0); every terminal tick goes to DONE.

## Test plan
- Reset/basic: n_rst low then high, start with load_val=5, prescale_val=0 at edge k -> count_out 5,4,3,2,1,0 on edges k..k+5; zero_flag high only after edge k+5; busy low from k+5.
- Prescale: load_val=3, prescale_val=2 -> decrements every 3 cycles, count_out=0 at edge k+9, single zero_flag pulse.
- Pause and clear: load_val=4, prescale 0, pause high 2 cycles after first decrement -> terminal delayed 2 cycles; clear mid-RUN -> count_out=0, busy=0, no zero_flag.
- Zero load / restart: start with load_val=0 -> zero_flag pulse next cycle, busy never high; start load_val=7 during RUN at count 2 -> count_out=7, no zero_flag.
- Auto-reload (macro defined): load_val=2, prescale 1, reload_en=1 -> zero_flag every 4 cycles, count_out 2,1,2,1…; deassert reload_en -> next terminal goes to 0/DONE. Macro undefined: same stimulus stops after first pulse.
- Async reset mid-count: n_rst low at count_out=3 -> count_out=0, busy=0, zero_flag=0 immediately, state IDLE after release.
